// File: rtl/micro_sequencer.sv
// micro_sequencer: next-microaddress generator for a microprogrammed controller.
// Selects the next microstate from dispatch, fetch, jump, increment, conditional
// branch/dispatch, call and return; keeps a small return stack and forces a
// fault state after too many consecutive self-loop cycles.
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   hold               freeze all state (no push/pop, counter kept)
//   current_state      microstate currently presented by the microstore
//   n_sel, cr_field    next-address select and target field of the control word
//   cond_sel, inv      condition select (moc, cond_in, 1, 0) and inversion
//   moc, cond_in       condition sources
//   dispatch_addr      opcode dispatch target
//   next_state         registered next microstate address
//   stack_level        number of valid return-stack entries
//   stack_ovf/unf      sticky stack overflow / underflow flags
//   timeout            sticky self-loop timeout flag
module micro_sequencer #(
   parameter int unsigned AW          = 10,
   parameter int unsigned STACK_DEPTH = 4,
   parameter int unsigned TIMEOUT     = 255,
   parameter int unsigned FAULT_STATE = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          hold,
   input  logic [AW-1:0] current_state,
   input  logic [2:0]    n_sel,
   input  logic [AW-1:0] cr_field,
   input  logic [1:0]    cond_sel,
   input  logic          inv,
   input  logic          moc,
   input  logic          cond_in,
   input  logic [AW-1:0] dispatch_addr,
   output logic [AW-1:0] next_state,
   output logic [2:0]    stack_level,
   output logic          stack_ovf,
   output logic          stack_unf,
   output logic          timeout
);

   localparam int unsigned SW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   logic [AW-1:0] stack_mem [STACK_DEPTH];
   logic [CW-1:0] wait_cnt;

   logic          cond_raw;
   logic          cond;
   logic [AW-1:0] inc;
   logic [AW-1:0] nxt;
   logic [AW-1:0] top;
   logic          push;
   logic          pop;
   logic          full;
   logic          empty;
   logic          self_loop;
   logic          fault;

   // Next-address selection and stack/timeout decisions
   always_comb begin
      cond_raw = 1'b0;
      nxt      = '0;
      push     = 1'b0;
      pop      = 1'b0;

      unique case (cond_sel)
         2'd0:    cond_raw = moc;
         2'd1:    cond_raw = cond_in;
         2'd2:    cond_raw = 1'b1;
         default: cond_raw = 1'b0;
      endcase
      cond = cond_raw ^ inv;

      inc   = current_state + AW'(1);
      full  = (stack_level == 3'(STACK_DEPTH));
      empty = (stack_level == 3'd0);
      // Index wraps when empty; the value is never used in that case.
      top   = stack_mem[SW'(stack_level - 3'd1)];

      unique case (n_sel)
         3'd0: nxt = dispatch_addr;
         3'd1: nxt = '0;
         3'd2: nxt = cr_field;
         3'd3: nxt = inc;
         3'd4: nxt = cond ? cr_field : inc;
         3'd5: nxt = cond ? cr_field : dispatch_addr;
         3'd6: begin
            nxt  = cr_field;
            push = 1'b1;
         end
         default: begin
            nxt = empty ? '0 : top;
            pop = 1'b1;
         end
      endcase

      // Fault fires on the TIMEOUT-th consecutive self-loop cycle
      self_loop = (nxt == current_state);
      fault     = self_loop && (wait_cnt == CW'(TIMEOUT - 1));
   end

   // State, stack and sticky-flag registers
   always_ff @(posedge clk) begin
      if (reset) begin
         next_state  <= '0;
         stack_level <= '0;
         wait_cnt    <= '0;
         stack_ovf   <= 1'b0;
         stack_unf   <= 1'b0;
         timeout     <= 1'b0;
         for (int i = 0; i < int'(STACK_DEPTH); i++) stack_mem[i] <= '0;
      end else if (!hold) begin
         if (fault) begin
            next_state <= AW'(FAULT_STATE);
            timeout    <= 1'b1;
            wait_cnt   <= '0;
         end else begin
            next_state <= nxt;
            wait_cnt   <= self_loop ? wait_cnt + CW'(1) : '0;
            if (push) begin
               if (full) begin
                  stack_ovf <= 1'b1;
               end else begin
                  stack_mem[SW'(stack_level)] <= inc;
                  stack_level <= stack_level + 3'd1;
               end
            end
            if (pop) begin
               if (empty) stack_unf <= 1'b1;
               else       stack_level <= stack_level - 3'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed-vector scoreboard bench for micro_sequencer.
// Each vector drives inputs at the falling edge and queues the hand-computed
// register contents expected after the next rising edge; a monitor pops and
// compares one entry per rising edge.
module tb_micro_sequencer;

   typedef struct {
      string      tag;
      logic [9:0] ns;
      logic [2:0] lvl;
      logic       ovf;
      logic       unf;
      logic       to;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       hold;
   logic [9:0] current_state;
   logic [2:0] n_sel;
   logic [9:0] cr_field;
   logic [1:0] cond_sel;
   logic       inv;
   logic       moc;
   logic       cond_in;
   logic [9:0] dispatch_addr;
   logic [9:0] next_state;
   logic [2:0] stack_level;
   logic       stack_ovf;
   logic       stack_unf;
   logic       timeout;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   micro_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .hold          (hold),
      .current_state (current_state),
      .n_sel         (n_sel),
      .cr_field      (cr_field),
      .cond_sel      (cond_sel),
      .inv           (inv),
      .moc           (moc),
      .cond_in       (cond_in),
      .dispatch_addr (dispatch_addr),
      .next_state    (next_state),
      .stack_level   (stack_level),
      .stack_ovf     (stack_ovf),
      .stack_unf     (stack_unf),
      .timeout       (timeout)
   );

   always #5 clk = ~clk;

   // Monitor: registered outputs settle just after each rising edge
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         vectors++;
         if (next_state !== e.ns || stack_level !== e.lvl || stack_ovf !== e.ovf ||
             stack_unf !== e.unf || timeout !== e.to) begin
            miscompares++;
            $display("FAIL %s: got ns=%h lvl=%0d ovf=%b unf=%b to=%b, expected ns=%h lvl=%0d ovf=%b unf=%b to=%b",
                     e.tag, next_state, stack_level, stack_ovf, stack_unf, timeout,
                     e.ns, e.lvl, e.ovf, e.unf, e.to);
         end
      end
   end

   // Apply one vector for one clock and queue its expected result
   task automatic vec(input string t, input logic [2:0] sel, input logic [9:0] cs,
                      input logic [9:0] cr, input logic [9:0] ens, input logic [2:0] elvl,
                      input logic eovf, input logic eunf, input logic eto);
      exp_t e;
      n_sel         = sel;
      current_state = cs;
      cr_field      = cr;
      e.tag = t; e.ns = ens; e.lvl = elvl; e.ovf = eovf; e.unf = eunf; e.to = eto;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      vec("reset", 3'd3, 10'h005, 10'h000, 10'h000, 3'd0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b0; hold = 1'b0; current_state = '0; n_sel = '0; cr_field = '0;
      cond_sel = 2'd0; inv = 1'b0; moc = 1'b0; cond_in = 1'b0; dispatch_addr = '0;
      @(negedge clk);
      do_reset();

      // Address wrap and basic selects
      vec("inc_wrap", 3'd3, 10'h3FF, 10'h000, 10'h000, 3'd0, 0, 0, 0);
      dispatch_addr = 10'h123;
      vec("dispatch", 3'd0, 10'h100, 10'h000, 10'h123, 3'd0, 0, 0, 0);
      vec("fetch",    3'd1, 10'h100, 10'h000, 10'h000, 3'd0, 0, 0, 0);
      vec("jump",     3'd2, 10'h100, 10'h2AA, 10'h2AA, 3'd0, 0, 0, 0);
      cond_sel = 2'd3;
      vec("br_const0",   3'd4, 10'h100, 10'h2AA, 10'h101, 3'd0, 0, 0, 0);
      cond_sel = 2'd2;
      vec("br_const1",   3'd4, 10'h100, 10'h2AA, 10'h2AA, 3'd0, 0, 0, 0);
      cond_sel = 2'd3; inv = 1'b1;
      vec("br_inv0",     3'd4, 10'h100, 10'h2AA, 10'h2AA, 3'd0, 0, 0, 0);
      cond_sel = 2'd0; inv = 1'b0; moc = 1'b1;
      vec("br_moc1",     3'd4, 10'h100, 10'h2AA, 10'h2AA, 3'd0, 0, 0, 0);
      moc = 1'b0;
      vec("br_moc0",     3'd4, 10'h100, 10'h2AA, 10'h101, 3'd0, 0, 0, 0);
      cond_sel = 2'd1; cond_in = 1'b0; dispatch_addr = 10'h055;
      vec("cdisp_false", 3'd5, 10'h100, 10'h07E, 10'h055, 3'd0, 0, 0, 0);
      cond_in = 1'b1;
      vec("cdisp_true",  3'd5, 10'h100, 10'h07E, 10'h07E, 3'd0, 0, 0, 0);
      cond_in = 1'b0; cond_sel = 2'd0;

      // Nested calls past the stack depth, then returns past empty
      do_reset();
      vec("call1", 3'd6, 10'h010, 10'h040, 10'h040, 3'd1, 0, 0, 0);
      vec("call2", 3'd6, 10'h011, 10'h040, 10'h040, 3'd2, 0, 0, 0);
      vec("call3", 3'd6, 10'h012, 10'h040, 10'h040, 3'd3, 0, 0, 0);
      vec("call4", 3'd6, 10'h013, 10'h040, 10'h040, 3'd4, 0, 0, 0);
      vec("call5_ovf", 3'd6, 10'h014, 10'h040, 10'h040, 3'd4, 1, 0, 0);
      vec("ret1", 3'd7, 10'h040, 10'h000, 10'h014, 3'd3, 1, 0, 0);
      vec("ret2", 3'd7, 10'h040, 10'h000, 10'h013, 3'd2, 1, 0, 0);
      vec("ret3", 3'd7, 10'h040, 10'h000, 10'h012, 3'd1, 1, 0, 0);
      vec("ret4", 3'd7, 10'h040, 10'h000, 10'h011, 3'd0, 1, 0, 0);
      vec("ret5_unf", 3'd7, 10'h040, 10'h000, 10'h000, 3'd0, 1, 1, 0);

      // Hold freezes a pending call; exactly one push afterwards
      do_reset();
      hold = 1'b1;
      for (int i = 0; i < 3; i++)
         vec("hold_call", 3'd6, 10'h020, 10'h050, 10'h000, 3'd0, 0, 0, 0);
      hold = 1'b0;
      vec("call_after_hold", 3'd6, 10'h020, 10'h050, 10'h050, 3'd1, 0, 0, 0);
      vec("ret_after_hold",  3'd7, 10'h050, 10'h000, 10'h021, 3'd0, 0, 0, 0);
      vec("ret_single_push", 3'd7, 10'h021, 10'h000, 10'h000, 3'd0, 0, 1, 0);

      // Reset beats hold and discards stack contents
      do_reset();
      vec("sub_call1", 3'd6, 10'h030, 10'h060, 10'h060, 3'd1, 0, 0, 0);
      vec("sub_call2", 3'd6, 10'h060, 10'h070, 10'h070, 3'd2, 0, 0, 0);
      reset = 1'b1; hold = 1'b1;
      vec("reset_over_hold", 3'd6, 10'h070, 10'h080, 10'h000, 3'd0, 0, 0, 0);
      reset = 1'b0; hold = 1'b0;
      vec("ret_after_reset", 3'd7, 10'h070, 10'h000, 10'h000, 3'd0, 0, 1, 0);

      // Self-loop timeout: fault on the 255th consecutive loop cycle
      do_reset();
      cond_sel = 2'd0; inv = 1'b1; moc = 1'b0;
      for (int i = 0; i < 254; i++)
         vec("wait_loop", 3'd4, 10'h022, 10'h022, 10'h022, 3'd0, 0, 0, 0);
      vec("timeout_fault", 3'd4, 10'h022, 10'h022, 10'h000, 3'd0, 0, 0, 1);

      // moc on cycle 10 exits the loop and clears the counter
      do_reset();
      for (int i = 0; i < 9; i++)
         vec("wait_pre", 3'd4, 10'h022, 10'h022, 10'h022, 3'd0, 0, 0, 0);
      moc = 1'b1;
      vec("moc_exit", 3'd4, 10'h022, 10'h022, 10'h023, 3'd0, 0, 0, 0);
      moc = 1'b0;
      for (int i = 0; i < 254; i++)
         vec("wait_cleared", 3'd4, 10'h022, 10'h022, 10'h022, 3'd0, 0, 0, 0);
      vec("timeout_again", 3'd4, 10'h022, 10'h022, 10'h000, 3'd0, 0, 0, 1);

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 Parameter AW, default 10: microstate address width, matching the microstore next-state port.
REQ-002 Parameter STACK_DEPTH, default 4: micro-subroutine return stack entries.
REQ-003 Parameter TIMEOUT, default 255: maximum consecutive self-loop cycles before a fault.
REQ-004 Parameter FAULT_STATE, default 0: microstate forced on timeout.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 hold  input  1  freeze: next_state, stack and timeout counter keep their values.
REQ-008 current_state  input  AW  state currently presented by the microstore.
REQ-009 n_sel  input  3  next-address select field of the control word.
REQ-010 cr_field  input  AW  target-address field of the control word.
REQ-011 cond_sel  input  2  condition select: 0 moc, 1 cond_in, 2 constant 1, 3 constant 0.
REQ-012 inv  input  1  invert the selected condition.
REQ-013 moc  input  1  memory operation complete.
REQ-014 cond_in  input  1  branch condition from the condition tester.
REQ-015 dispatch_addr  input  AW  opcode dispatch target from the instruction encoder.
REQ-016 next_state  output  AW  registered microstate address driven to the microstore.
REQ-017 stack_level  output  3  number of valid stack entries (0..STACK_DEPTH).
REQ-018 stack_ovf, stack_unf, timeout  output  1 each  sticky error flags.

Function
REQ-019 The block SHALL register next_state: a decision made from inputs sampled at edge k appears on next_state after edge k (1-cycle latency).
REQ-020 The block SHALL compute the condition as C = sel(cond_sel) XOR inv.
REQ-021 The block SHALL compute inc = current_state + 1, modulo 2^AW; all-ones wraps to 0.
REQ-022 For n_sel=0 (dispatch), next_state SHALL be dispatch_addr.
REQ-023 For n_sel=1 (fetch), next_state SHALL be 0.
REQ-024 For n_sel=2 (jump), next_state SHALL be cr_field.
REQ-025 For n_sel=3 (increment), next_state SHALL be inc.
REQ-026 For n_sel=4 (conditional branch), next_state SHALL be cr_field if C, else inc.
REQ-027 For n_sel=5 (conditional dispatch), next_state SHALL be cr_field if C, else dispatch_addr.
REQ-028 For n_sel=6 (call), the block SHALL push inc and set next_state = cr_field.
REQ-029 For n_sel=7 (return), the block SHALL pop the top entry into next_state.
REQ-030 The stack SHALL be LIFO, with at most one push or one pop per cycle.
REQ-031 A call while stack_level=STACK_DEPTH SHALL leave the stack unmodified, set stack_ovf and still jump to cr_field.
REQ-032 A return while stack_level=0 SHALL set next_state = 0 and set stack_unf.
REQ-033 The wait counter SHALL increment on each non-hold cycle whose computed next equals current_state, and SHALL clear on any other non-hold cycle.
REQ-034 When the counter reaches TIMEOUT, next_state SHALL be FAULT_STATE, timeout SHALL be set, and the counter SHALL clear; this overrides every n_sel and any stack operation that cycle.
REQ-035 While hold=1, all registers SHALL keep their values and no push or pop SHALL occur.
REQ-036 Reset SHALL take priority over hold and over every n_sel.

Reset
REQ-037 On reset, next_state SHALL be 0, stack_level 0, the wait counter 0, and stack_ovf, stack_unf and timeout 0.
REQ-038 Reset asserted mid-subroutine SHALL discard all stack contents.
REQ-039 Sticky flags SHALL clear only on reset.

Verification
REQ-040 Reset, then n_sel=3 with current_state=0x3FF -> next_state=0x000, no flags set.
REQ-041 n_sel=4, cond_sel=0, inv=1, moc=0, cr_field=current_state=0x022 held for 255 cycles -> next_state=FAULT_STATE (0) and timeout=1 on cycle 255; with moc=1 on cycle 10 -> next_state=0x023 and the counter clears.
REQ-042 Five calls (current_state 0x10..0x14, cr_field 0x40) then five returns -> stack_ovf=1 after the 5th call; returns yield 0x14, 0x13, 0x12, 0x11, then 0x000 with stack_unf=1.
REQ-043 n_sel=5, cond_sel=1, inv=0, cond_in=0, dispatch_addr=0x055 -> next_state=0x055; with cond_in=1 and cr_field=0x07E -> next_state=0x07E.
REQ-044 hold=1 for 3 cycles during n_sel=6 -> next_state and stack_level unchanged; after hold drops, exactly one push occurs.
REQ-045 reset asserted with stack_level=2 and hold=1 -> next cycle next_state=0 and stack_level=0.
